gp_chunk_adder: RTL and testbench



---
 rtl/gp_chunk_adder_if.sv | 27 ++
 rtl/gp_chunk_adder.sv | 124 ++++++++++++
 tb/tb_gp_chunk_adder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_chunk_adder_if.sv
// Slice stream between operand staging, the chunk adder and the result packer.
interface gp_chunk_adder_if #(
    parameter int CHUNK_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic               cin;
    logic               out_valid;
    logic               out_ready;
    logic [CHUNK_W-1:0] sum_chunk;
    logic               group_g;
    logic               group_p;
    logic               out_last;
    logic               cout;

    modport master (
        output in_valid, a_chunk, b_chunk, cin, out_ready,
        input  in_ready, out_valid, sum_chunk, group_g, group_p, out_last, cout
    );

    modport slave (
        input  in_valid, a_chunk, b_chunk, cin, out_ready,
        output in_ready, out_valid, sum_chunk, group_g, group_p, out_last, cout
    );
endinterface

// File: rtl/gp_chunk_adder.sv
// Multi-beat G/P carry resolver: builds a CHUNK_W*NUM_CHUNKS-bit sum LSB slice first,
// with a single-entry registered output stage on a valid/ready stream.
module gp_chunk_adder #(
    parameter int CHUNK_W    = 8,
    parameter int NUM_CHUNKS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    gp_chunk_adder_if.slave bus,
    output logic            busy
);
    localparam int               CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               carry_q, carry_d;
    logic               out_valid_q, out_valid_d;
    logic [CHUNK_W-1:0] sum_q, sum_d;
    logic               gg_q, gg_d;
    logic               gp_q, gp_d;
    logic               last_q, last_d;
    logic               cout_q, cout_d;

    logic [CHUNK_W-1:0] g, p, sum;
    logic [CHUNK_W:0]   c, cg;
    logic               in_ready, accept, is_last;

    assign g = bus.a_chunk & bus.b_chunk;
    assign p = bus.a_chunk ^ bus.b_chunk;

    // Two ripples: c uses the real carry-in, cg assumes 0 to give the slice group-generate.
    always_comb begin
        c     = '0;
        cg    = '0;
        c[0]  = (state_q == IDLE) ? bus.cin : carry_q;
        for (int i = 0; i < CHUNK_W; i++) begin
            c[i+1]  = g[i] | (p[i] & c[i]);
            cg[i+1] = g[i] | (p[i] & cg[i]);
        end
    end

    assign sum      = p ^ c[CHUNK_W-1:0];
    assign is_last  = (beat_cnt_q == LAST_BEAT);
    assign in_ready = !flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        carry_d    = carry_q;
        if (flush) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            carry_d    = 1'b0;
        end else if (accept) begin
            if (is_last) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                carry_d    = 1'b0;
            end else begin
                state_d    = ACCUM;
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                carry_d    = c[CHUNK_W];
            end
        end
    end

    // Output stage holds while stalled; a flush never disturbs a slice already here.
    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        gg_d        = gg_q;
        gp_d        = gp_q;
        last_d      = last_q;
        cout_d      = cout_q;
        if (accept) begin
            out_valid_d = 1'b1;
            sum_d       = sum;
            gg_d        = cg[CHUNK_W];
            gp_d        = &p;
            last_d      = is_last;
            cout_d      = is_last ? c[CHUNK_W] : 1'b0;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            gg_q        <= 1'b0;
            gp_q        <= 1'b0;
            last_q      <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            gg_q        <= gg_d;
            gp_q        <= gp_d;
            last_q      <= last_d;
            cout_q      <= cout_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_chunk = sum_q;
    assign bus.group_g   = gg_q;
    assign bus.group_p   = gp_q;
    assign bus.out_last  = last_q;
    assign bus.cout      = cout_q;
    assign busy          = (beat_cnt_q != '0);
endmodule

// File: tb/tb_gp_chunk_adder.sv
// Bench for gp_chunk_adder: vector table, hand-written stall/flush/reset sequences,
// and random full-width adds checked against plain 33-bit arithmetic.
module tb_gp_chunk_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] hs_q[$];

    gp_chunk_adder_if #(.CHUNK_W(8)) bus();

    gp_chunk_adder #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs only change just after a posedge or at a negedge, so valid&ready here is a real handshake.
    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready) hs_q.push_back(bus.sum_chunk);

    typedef struct {
        logic [7:0] sum;
        logic gg, gp, last, cout, busy;
    } beat_exp_t;

    typedef struct {
        logic [31:0] a, b;
        logic        cin;
        logic [32:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offer one slice, wait for acceptance, then check the registered result one cycle later.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic c,
                             input beat_exp_t e, input string nm,
                             output logic [7:0] gs, output logic gc);
        int n;
        bus.in_valid = 1'b1;
        bus.a_chunk  = a;
        bus.b_chunk  = b;
        bus.cin      = c;
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL %s.accept_timeout: in_ready stuck low", nm);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, ".valid"}, bus.out_valid, 1'b1);
        chk({nm, ".sum"},   bus.sum_chunk, e.sum);
        chk({nm, ".gg"},    bus.group_g,   e.gg);
        chk({nm, ".gp"},    bus.group_p,   e.gp);
        chk({nm, ".last"},  bus.out_last,  e.last);
        chk({nm, ".cout"},  bus.cout,      e.cout);
        chk({nm, ".busy"},  busy,          e.busy);
        gs = bus.sum_chunk;
        gc = bus.cout;
    endtask

    // Reference: whole add as one 33-bit sum, slice group terms from 9-bit slice sums.
    task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input string nm, output logic [32:0] got);
        logic [32:0] full;
        logic [8:0]  s9;
        logic [7:0]  sa, sb, gs;
        logic        gc, cb;
        beat_exp_t   e;
        full = {1'b0, a} + {1'b0, b} + 33'(cin);
        got  = '0;
        for (int k = 0; k < 4; k++) begin
            sa     = a[8*k +: 8];
            sb     = b[8*k +: 8];
            s9     = {1'b0, sa} + {1'b0, sb};
            e.sum  = full[8*k +: 8];
            e.gg   = s9[8];
            e.gp   = ((sa ^ sb) == 8'hFF);
            e.last = (k == 3);
            e.cout = (k == 3) ? full[32] : 1'b0;
            e.busy = (k != 3);
            cb     = (k == 0) ? cin : 1'($urandom_range(0, 1));
            send_beat(sa, sb, cb, e, $sformatf("%s.b%0d", nm, k), gs, gc);
            got[8*k +: 8] = gs;
            if (k == 3) got[32] = gc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [32:0] got;
        logic [7:0]  gs;
        logic        gc;
        logic [31:0] ra, rb;
        logic        rc;

        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000};
        tbl[1] = '{32'h12345678, 32'h11111111, 1'b1, 33'h0_2345678A};
        tbl[2] = '{32'h000000FF, 32'h00000001, 1'b0, 33'h0_00000100};
        tbl[3] = '{32'h00000001, 32'h00000001, 1'b0, 33'h0_00000002};
        tbl[4] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 33'h1_55555554};
        tbl[5] = '{32'h80000000, 32'h80000000, 1'b1, 33'h1_00000001};

        bus.in_valid  = 1'b0;
        bus.a_chunk   = '0;
        bus.b_chunk   = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", bus.out_valid, 1'b0);
        chk("rst.sum",   bus.sum_chunk, 8'h00);
        chk("rst.gg",    bus.group_g,   1'b0);
        chk("rst.gp",    bus.group_p,   1'b0);
        chk("rst.last",  bus.out_last,  1'b0);
        chk("rst.cout",  bus.cout,      1'b0);
        chk("rst.busy",  busy,          1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripple with explicit slice expectations
        send_beat(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, "ripple.b0", gs, gc);
        send_beat(8'hFF, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, "ripple.b1", gs, gc);
        send_beat(8'hFF, 8'h00, 1'b1, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, "ripple.b2", gs, gc);
        send_beat(8'hFF, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}, "ripple.b3", gs, gc);

        // Both bits set: generate without propagate, carry feeds beat 1
        send_beat(8'hAA, 8'hAA, 1'b0, '{8'h54, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, "gp.b0", gs, gc);
        send_beat(8'h00, 8'h00, 1'b0, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, "gp.b1", gs, gc);
        send_beat(8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, "gp.b2", gs, gc);
        send_beat(8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "gp.b3", gs, gc);

        for (int i = 0; i < 6; i++) begin
            run_add(tbl[i].a, tbl[i].b, tbl[i].cin, $sformatf("tbl%0d", i), got);
            chk($sformatf("tbl%0d.result", i), got, tbl[i].exp);
        end

        // Backpressure: beat-0 result stalls 3 cycles with the next slice waiting
        idle_cycle();
        hs_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a_chunk   = 8'h78;
        bus.b_chunk   = 8'h11;
        bus.cin       = 1'b1;
        @(negedge clk);
        chk("bp.first_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.a_chunk = 8'h56;
        bus.b_chunk = 8'h11;
        bus.cin     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp.stall%0d.ready", i), bus.in_ready,  1'b0);
            chk($sformatf("bp.stall%0d.valid", i), bus.out_valid, 1'b1);
            chk($sformatf("bp.stall%0d.sum", i),   bus.sum_chunk, 8'h8A);
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp.refill_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp.b1.sum", bus.sum_chunk, 8'h67);
        send_beat(8'h34, 8'h11, 1'b0, '{8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, "bp.b2", gs, gc);
        send_beat(8'h12, 8'h11, 1'b0, '{8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, "bp.b3", gs, gc);
        idle_cycle();
        chk("bp.hs_count", hs_q.size(), 4);
        if (hs_q.size() == 4) begin
            chk("bp.hs0", hs_q[0], 8'h8A);
            chk("bp.hs1", hs_q[1], 8'h67);
            chk("bp.hs2", hs_q[2], 8'h45);
            chk("bp.hs3", hs_q[3], 8'h23);
        end

        // Flush after two beats with a pending carry
        idle_cycle();
        send_beat(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, "fl.b0", gs, gc);
        send_beat(8'hFF, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, "fl.b1", gs, gc);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_chunk  = 8'h12;
        bus.b_chunk  = 8'h00;
        #1;
        chk("fl.in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl.no_accept", bus.out_valid, 1'b0);
        chk("fl.busy",      busy,          1'b0);
        run_add(32'h00000001, 32'h00000001, 1'b0, "fl.after", got);
        chk("fl.after.result", got, 33'h0_00000002);

        // Async reset while beat 2 is being offered
        idle_cycle();
        send_beat(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}, "ar.b0", gs, gc);
        send_beat(8'hFF, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, "ar.b1", gs, gc);
        bus.in_valid = 1'b1;
        bus.a_chunk  = 8'hFF;
        bus.b_chunk  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", bus.out_valid, 1'b0);
        chk("ar.sum",   bus.sum_chunk, 8'h00);
        chk("ar.gg",    bus.group_g,   1'b0);
        chk("ar.gp",    bus.group_p,   1'b0);
        chk("ar.last",  bus.out_last,  1'b0);
        chk("ar.cout",  bus.cout,      1'b0);
        chk("ar.busy",  busy,          1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_add(32'h000000FF, 32'h00000001, 1'b0, "ar.after", got);
        chk("ar.after.result", got, 33'h0_00000100);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            run_add(ra, rb, rc, $sformatf("rnd%0d", i), got);
            chk($sformatf("rnd%0d.result", i), got, {1'b0, ra} + {1'b0, rb} + 33'(rc));
        end

        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
